// File: rtl/screen_crossfader.sv
// Screen crossfader: picks one of NUM_SCREENS renderer channels per pixel and,
// when the requested screen changes, blends old to new over 2^FADE_SHIFT
// frames. Screen/alpha updates happen only on frame_start, so a frame never
// tears. The two-stage pixel pipeline gives a fixed 2-cycle latency.
module screen_crossfader #(
   parameter  int NUM_SCREENS = 4,
   parameter  int MAX_POS     = 109,
   parameter  int INTENSITY_W = 8,
   parameter  int FADE_SHIFT  = 4,
   localparam int SEL_W       = $clog2(NUM_SCREENS),
   localparam int LED_W       = $clog2(MAX_POS)
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               frame_start,
   input  logic [SEL_W-1:0]                   current_screen,
   input  logic                               valid_in,
   input  logic [LED_W-1:0]                   current_led,
   input  logic [NUM_SCREENS*INTENSITY_W-1:0] scr_green,
   input  logic [NUM_SCREENS*INTENSITY_W-1:0] scr_red,
   input  logic [NUM_SCREENS*INTENSITY_W-1:0] scr_blue,
   output logic                               o_valid,
   output logic [LED_W-1:0]                   o_led,
   output logic [INTENSITY_W-1:0]             o_green,
   output logic [INTENSITY_W-1:0]             o_red,
   output logic [INTENSITY_W-1:0]             o_blue,
   output logic [SEL_W-1:0]                   active_screen,
   output logic                               fading
);

   localparam int AW = FADE_SHIFT + 1;                 // alpha spans 0..2^FADE_SHIFT
   localparam int PW = INTENSITY_W + FADE_SHIFT + 1;   // product / sum width
   localparam logic [AW-1:0]    ALPHA_FULL = AW'(1 << FADE_SHIFT);
   localparam logic [SEL_W:0]   NUM_SEL    = (SEL_W + 1)'(NUM_SCREENS);

   typedef enum logic {STEADY, FADE} state_e;

   state_e           state_q,   state_d;
   logic [AW-1:0]    alpha_q,   alpha_d;
   logic [SEL_W-1:0] active_q,  active_d;
   logic [SEL_W-1:0] prev_q,    prev_d;
   logic [SEL_W-1:0] pending_q, pending_d;

   // Per-component channel views: index 0 = green, 1 = red, 2 = blue.
   logic [INTENSITY_W-1:0] ch [3][NUM_SCREENS];

   for (genvar k = 0; k < NUM_SCREENS; k++) begin : g_unpack
      assign ch[0][k] = scr_green[k*INTENSITY_W +: INTENSITY_W];
      assign ch[1][k] = scr_red  [k*INTENSITY_W +: INTENSITY_W];
      assign ch[2][k] = scr_blue [k*INTENSITY_W +: INTENSITY_W];
   end

   // Out-of-range screen requests are dropped; the last valid request stands.
   assign pending_d = ({1'b0, current_screen} < NUM_SEL) ? current_screen : pending_q;

   // Fade controller state: screens, alpha and the latched request.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (reset) begin
         state_q   <= STEADY;
         alpha_q   <= ALPHA_FULL;
         active_q  <= '0;
         prev_q    <= '0;
         pending_q <= '0;
      end else begin
         state_q   <= state_d;
         alpha_q   <= alpha_d;
         active_q  <= active_d;
         prev_q    <= prev_d;
         pending_q <= pending_d;
      end
   end

   // Next-state: a new request (re)starts the fade, otherwise alpha ramps up.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      state_d  = state_q;
      alpha_d  = alpha_q;
      active_d = active_q;
      prev_d   = prev_q;
      if (frame_start) begin
         if (pending_q != active_q) begin
            prev_d   = active_q;
            active_d = pending_q;
            if (FADE_SHIFT > 0) begin
               alpha_d = '0;
               state_d = FADE;
            end
         end else if (state_q == FADE) begin
            alpha_d = alpha_q + 1'b1;
            if (alpha_d == ALPHA_FULL) state_d = STEADY;
         end
      end
   end

   // Controller outputs.
   always_comb begin
      fading        = (state_q == FADE);
      active_screen = active_q;
   end

   // Stage 1 operands: weighted new and old channel per component.
   logic [PW-1:0] alpha_ext, inv_ext;
   logic [PW-1:0] prod_new [3];
   logic [PW-1:0] prod_old [3];

   assign alpha_ext = PW'(alpha_q);
   assign inv_ext   = PW'(ALPHA_FULL - alpha_q);

   // Products for the incoming pixel using the pre-update alpha and screens.
   always_comb begin
      for (int c = 0; c < 3; c++) begin
         prod_new[c] = PW'(ch[c][active_q]) * alpha_ext;
         prod_old[c] = PW'(ch[c][prev_q])   * inv_ext;
      end
   end

   logic          s1_valid_q;
   logic [LED_W-1:0] s1_led_q;
   logic [PW-1:0] s1_new_q [3];
   logic [PW-1:0] s1_old_q [3];

   // Stage 1 register: products, LED index and qualifier.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s1_led_q   <= '0;
         // NOTE: these small arrays are plain flops, not RAM, so they take
         // a reset like any other register.
         for (int c = 0; c < 3; c++) begin
            s1_new_q[c] <= '0;
            s1_old_q[c] <= '0;
         end
      end else begin
         s1_valid_q <= valid_in;
         if (valid_in) begin
            s1_led_q <= current_led;
            for (int c = 0; c < 3; c++) begin
               s1_new_q[c] <= prod_new[c];
               s1_old_q[c] <= prod_old[c];
            end
         end
      end
   end

   logic [INTENSITY_W-1:0] mix [3];

   // Blend: the sum never exceeds (2^W-1)*2^FADE_SHIFT, so truncation is safe.
   always_comb begin
      for (int c = 0; c < 3; c++) begin
         mix[c] = INTENSITY_W'((s1_new_q[c] + s1_old_q[c]) >> FADE_SHIFT);
      end
   end

   logic                   o_valid_q;
   logic [LED_W-1:0]       o_led_q;
   logic [INTENSITY_W-1:0] o_col_q [3];

   // Stage 2 register: colours hold their last value while no pixel arrives.
   always_ff @(posedge clk) begin
      if (reset) begin
         o_valid_q <= 1'b0;
         o_led_q   <= '0;
         for (int c = 0; c < 3; c++) o_col_q[c] <= '0;
      end else begin
         o_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            o_led_q <= s1_led_q;
            for (int c = 0; c < 3; c++) o_col_q[c] <= mix[c];
         end
      end
   end

   assign o_valid = o_valid_q;
   assign o_led   = o_led_q;
   assign o_green = o_col_q[0];
   assign o_red   = o_col_q[1];
   assign o_blue  = o_col_q[2];

endmodule
